// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined LEGv8 control unit: opcodes, ALUOP codes,
// and the control bundles carried through the ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

   localparam int OPC_W = 11;
   localparam int RA_W  = 5;
   localparam int AOP_W = 2;

   localparam logic [RA_W-1:0] XZR = 5'd31;

   localparam logic [AOP_W-1:0] ALUOP_MEM   = 2'b00;
   localparam logic [AOP_W-1:0] ALUOP_CBZ   = 2'b01;
   localparam logic [AOP_W-1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [OPC_W-1:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [OPC_W-1:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [OPC_W-1:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [OPC_W-1:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [OPC_W-1:0] OP_AND  = 11'b100_0101_0000;
   localparam logic [OPC_W-1:0] OP_ORR  = 11'b101_0101_0000;
   localparam logic [OPC_W-1:0] OP_LSL  = 11'b110_1001_1011;
   localparam logic [OPC_W-1:0] OP_LSR  = 11'b110_1001_1010;
   // CBZ and B carry address bits in the low opcode bits, so only a prefix is decoded
   localparam logic [7:0]       OP_CBZ_PFX = 8'b1011_0100;
   localparam logic [5:0]       OP_B_PFX   = 6'b00_0101;

   typedef struct packed {
      logic             reg2loc;
      logic             alusrc;
      logic [AOP_W-1:0] aluop;
      logic             memread;
      logic             memwrite;
      logic             branch;
      logic             uncon_branch;
      logic             regwrite;
      logic             memtoreg;
   } ctrl_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic branch;
      logic uncon_branch;
      logic regwrite;
      logic memtoreg;
   } mem_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
   } wb_ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic mem_ctrl_t to_mem(input ctrl_t c);
      mem_ctrl_t m;
      m.memread      = c.memread;
      m.memwrite     = c.memwrite;
      m.branch       = c.branch;
      m.uncon_branch = c.uncon_branch;
      m.regwrite     = c.regwrite;
      m.memtoreg     = c.memtoreg;
      return m;
   endfunction

   function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
      wb_ctrl_t w;
      w.regwrite = m.regwrite;
      w.memtoreg = m.memtoreg;
      return w;
   endfunction

endpackage

// File: rtl/pipe_control_unit_ctrl_decode.sv
// Combinational ID-stage decoder: opcode to control bundle, illegal flag and
// which register fields the instruction reads (for load-use detection).
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic             valid,
   output ctrl_t            ctrl,
   output logic             illegal,
   output logic             use_rn,
   output logic             use_rm,
   output logic             use_rt
);

   always_comb begin
      ctrl    = CTRL_NOP;
      illegal = 1'b0;
      use_rn  = 1'b0;
      use_rm  = 1'b0;
      use_rt  = 1'b0;
      if (valid) begin
         use_rn = 1'b1;
         if (opcode[10:3] == OP_CBZ_PFX) begin
            ctrl.reg2loc = 1'b1;
            ctrl.branch  = 1'b1;
            ctrl.aluop   = ALUOP_CBZ;
            use_rt       = 1'b1;
         end else if (opcode[10:5] == OP_B_PFX) begin
            ctrl.uncon_branch = 1'b1;
            use_rn            = 1'b0;
         end else begin
            case (opcode)
               OP_LDUR: begin
                  ctrl.alusrc   = 1'b1;
                  ctrl.memtoreg = 1'b1;
                  ctrl.regwrite = 1'b1;
                  ctrl.memread  = 1'b1;
                  ctrl.aluop    = ALUOP_MEM;
               end
               OP_STUR: begin
                  ctrl.reg2loc  = 1'b1;
                  ctrl.alusrc   = 1'b1;
                  ctrl.memwrite = 1'b1;
                  ctrl.aluop    = ALUOP_MEM;
                  use_rt        = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                  ctrl.regwrite = 1'b1;
                  ctrl.aluop    = ALUOP_RTYPE;
                  use_rm        = 1'b1;
               end
               // shifts take shamt in place of Rm
               OP_LSL, OP_LSR: begin
                  ctrl.regwrite = 1'b1;
                  ctrl.aluop    = ALUOP_RTYPE;
                  ctrl.alusrc   = 1'b1;
               end
               default: begin
                  illegal = 1'b1;
                  use_rn  = 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decode, ID/EX/MEM/WB control registers, load-use stall
// and taken-branch flush. Define PIPE_PERF_COUNTERS_EN to add stall/flush/retire counters.
module pipe_control_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 11,
   parameter int REG_W    = 5,
   parameter int ALUOP_W  = 2
`ifdef PIPE_PERF_COUNTERS_EN
   ,
   parameter int CNT_W    = 32
`endif
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic [31:0]         if_id_instr,
   input  logic                if_id_valid,
   input  logic                branch_taken,
   output logic                stall,
   output logic                flush_if_id,
   output logic                illegal_op,
   output logic                ex_alusrc,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [OPCODE_W-1:0] ex_opcode,
   output logic                ex_reg2loc,
   output logic                mem_memread,
   output logic                mem_memwrite,
   output logic                mem_branch,
   output logic                mem_uncon_branch,
   output logic                wb_regwrite,
   output logic                wb_memtoreg,
   output logic [REG_W-1:0]    wb_rd
`ifdef PIPE_PERF_COUNTERS_EN
   ,
   output logic [CNT_W-1:0]    cnt_stall,
   output logic [CNT_W-1:0]    cnt_flush,
   output logic [CNT_W-1:0]    cnt_retired
`endif
);

   logic [OPC_W-1:0] id_opcode;
   logic [RA_W-1:0]  id_rn, id_rm, id_rt;
   ctrl_t            id_ctrl_raw, id_ctrl;
   logic             use_rn, use_rm, use_rt;
   logic             hazard;
   logic             unused_shamt;

   ctrl_t            idex_ctrl_q, idex_ctrl_d;
   logic [OPC_W-1:0] idex_op_q, idex_op_d;
   logic [RA_W-1:0]  idex_rd_q, idex_rd_d;
   mem_ctrl_t        exmem_ctrl_q, exmem_ctrl_d;
   logic [RA_W-1:0]  exmem_rd_q, exmem_rd_d;
   wb_ctrl_t         memwb_ctrl_q, memwb_ctrl_d;
   logic [RA_W-1:0]  memwb_rd_q, memwb_rd_d;

   assign id_opcode    = if_id_instr[31:21];
   assign id_rm        = if_id_instr[20:16];
   assign id_rn        = if_id_instr[9:5];
   assign id_rt        = if_id_instr[4:0];
   assign unused_shamt = ^if_id_instr[15:10];

   ctrl_decode u_ctrl_decode (
      .opcode  (id_opcode),
      .valid   (if_id_valid),
      .ctrl    (id_ctrl_raw),
      .illegal (illegal_op),
      .use_rn  (use_rn),
      .use_rm  (use_rm),
      .use_rt  (use_rt)
   );

   // writes to XZR are discarded
   always_comb begin
      id_ctrl = id_ctrl_raw;
      if (id_rt == XZR) id_ctrl.regwrite = 1'b0;
   end

   assign hazard = idex_ctrl_q.memread && (idex_rd_q != XZR) &&
                   ((use_rn && (id_rn == idex_rd_q)) ||
                    (use_rm && (id_rm == idex_rd_q)) ||
                    (use_rt && (id_rt == idex_rd_q)));

   assign stall       = hazard && !branch_taken;
   assign flush_if_id = branch_taken;

   always_comb begin
      idex_ctrl_d  = id_ctrl;
      idex_op_d    = if_id_valid ? id_opcode : '0;
      idex_rd_d    = if_id_valid ? id_rt : '0;
      exmem_ctrl_d = to_mem(idex_ctrl_q);
      exmem_rd_d   = idex_rd_q;
      memwb_ctrl_d = to_wb(exmem_ctrl_q);
      memwb_rd_d   = exmem_rd_q;
      if (branch_taken) begin
         idex_ctrl_d  = CTRL_NOP;
         idex_op_d    = '0;
         idex_rd_d    = '0;
         exmem_ctrl_d = '0;
         exmem_rd_d   = '0;
      end else if (hazard) begin
         idex_ctrl_d = CTRL_NOP;
         idex_op_d   = '0;
         idex_rd_d   = '0;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         idex_ctrl_q  <= CTRL_NOP;
         idex_op_q    <= '0;
         idex_rd_q    <= '0;
         exmem_ctrl_q <= '0;
         exmem_rd_q   <= '0;
         memwb_ctrl_q <= '0;
         memwb_rd_q   <= '0;
      end else begin
         idex_ctrl_q  <= idex_ctrl_d;
         idex_op_q    <= idex_op_d;
         idex_rd_q    <= idex_rd_d;
         exmem_ctrl_q <= exmem_ctrl_d;
         exmem_rd_q   <= exmem_rd_d;
         memwb_ctrl_q <= memwb_ctrl_d;
         memwb_rd_q   <= memwb_rd_d;
      end
   end

   assign ex_alusrc        = idex_ctrl_q.alusrc;
   assign ex_aluop         = idex_ctrl_q.aluop;
   assign ex_opcode        = idex_op_q;
   assign ex_reg2loc       = idex_ctrl_q.reg2loc;
   assign mem_memread      = exmem_ctrl_q.memread;
   assign mem_memwrite     = exmem_ctrl_q.memwrite;
   assign mem_branch       = exmem_ctrl_q.branch;
   assign mem_uncon_branch = exmem_ctrl_q.uncon_branch;
   assign wb_regwrite      = memwb_ctrl_q.regwrite;
   assign wb_memtoreg      = memwb_ctrl_q.memtoreg;
   assign wb_rd            = memwb_rd_q;

`ifdef PIPE_PERF_COUNTERS_EN
   logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
   logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
   logic [CNT_W-1:0] cnt_retired_q, cnt_retired_d;

   always_comb begin
      cnt_stall_d   = cnt_stall_q + CNT_W'(stall);
      cnt_flush_d   = cnt_flush_q + CNT_W'(branch_taken);
      cnt_retired_d = cnt_retired_q + CNT_W'(memwb_ctrl_q != '0);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cnt_stall_q   <= '0;
         cnt_flush_q   <= '0;
         cnt_retired_q <= '0;
      end else begin
         cnt_stall_q   <= cnt_stall_d;
         cnt_flush_q   <= cnt_flush_d;
         cnt_retired_q <= cnt_retired_d;
      end
   end

   assign cnt_stall   = cnt_stall_q;
   assign cnt_flush   = cnt_flush_q;
   assign cnt_retired = cnt_retired_q;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: directed hazard/flush/reset scenarios
// followed by random instruction streams checked against a stage-slot reference model.
module tb_pipe_control_unit;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] if_id_instr = '0;
   logic        if_id_valid = 1'b0;
   logic        branch_taken = 1'b0;
   logic        stall, flush_if_id, illegal_op;
   logic        ex_alusrc, ex_reg2loc;
   logic [1:0]  ex_aluop;
   logic [10:0] ex_opcode;
   logic        mem_memread, mem_memwrite, mem_branch, mem_uncon_branch;
   logic        wb_regwrite, wb_memtoreg;
   logic [4:0]  wb_rd;
`ifdef PIPE_PERF_COUNTERS_EN
   logic [31:0] cnt_stall, cnt_flush, cnt_retired;
`endif

   pipe_control_unit dut (
      .CLOCK(CLOCK), .RESET(RESET), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .branch_taken(branch_taken), .stall(stall), .flush_if_id(flush_if_id),
      .illegal_op(illegal_op), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .ex_opcode(ex_opcode), .ex_reg2loc(ex_reg2loc), .mem_memread(mem_memread),
      .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
      .mem_uncon_branch(mem_uncon_branch), .wb_regwrite(wb_regwrite),
      .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
`ifdef PIPE_PERF_COUNTERS_EN
      , .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_retired(cnt_retired)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct packed {
      logic        reg2loc, alusrc;
      logic [1:0]  aluop;
      logic        memread, memwrite, branch, uncon, regwrite, memtoreg;
      logic [10:0] op;
      logic [4:0]  rd;
   } slot_t;

   typedef struct packed {
      logic  known, use_rn, use_rm, use_rt;
      slot_t s;
   } dec_t;

   typedef struct {
      logic        stall, flush, illegal;
      slot_t       ex, mem, wb;
      logic [31:0] c_stall, c_flush, c_ret;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_err = 0;
   slot_t       m_ex = '0, m_mem = '0, m_wb = '0;
   logic [31:0] m_c_stall = 0, m_c_flush = 0, m_c_ret = 0;
   logic        prev_stall = 0, prev_bt = 0;

   localparam logic [31:0] I_LDUR_X1  = 32'hF840_0041;  // LDUR X1,[X2]
   localparam logic [31:0] I_ADD_X3   = 32'h8B04_0023;  // ADD X3,X1,X4
   localparam logic [31:0] I_LDUR_XZR = 32'hF840_005F;  // LDUR X31,[X2]
   localparam logic [31:0] I_ADD_XZR  = 32'h8B04_03E3;  // ADD X3,X31,X4
   localparam logic [31:0] I_CBZ_X5   = 32'hB400_0005;  // CBZ X5
   localparam logic [31:0] I_ADD_X7   = 32'h8B09_0107;  // ADD X7,X8,X9
   localparam logic [31:0] I_ILLEGAL  = 32'hFFE0_0003;  // opcode 7FF

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Control values by mnemonic, straight from the ISA subset's table.
   function automatic dec_t ref_decode(input logic [31:0] ins, input logic v);
      dec_t        d;
      logic [10:0] op;
      d  = '0;
      op = ins[31:21];
      if (!v) return d;
      d.known = 1'b1;
      d.s.op  = op;
      d.s.rd  = ins[4:0];
      if (op == 11'h7C2) begin
         d.s.alusrc = 1; d.s.memtoreg = 1; d.s.regwrite = 1; d.s.memread = 1; d.use_rn = 1;
      end else if (op == 11'h7C0) begin
         d.s.reg2loc = 1; d.s.alusrc = 1; d.s.memwrite = 1; d.use_rn = 1; d.use_rt = 1;
      end else if (op[10:3] == 8'hB4) begin
         d.s.reg2loc = 1; d.s.branch = 1; d.s.aluop = 2'b01; d.use_rn = 1; d.use_rt = 1;
      end else if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
         d.s.regwrite = 1; d.s.aluop = 2'b10; d.use_rn = 1; d.use_rm = 1;
      end else if (op == 11'h69B || op == 11'h69A) begin
         d.s.regwrite = 1; d.s.aluop = 2'b10; d.s.alusrc = 1; d.use_rn = 1;
      end else if (op[10:5] == 6'b000101) begin
         d.s.uncon = 1;
      end else begin
         d.known = 1'b0;
      end
      if (d.s.rd == 5'd31) d.s.regwrite = 1'b0;
      return d;
   endfunction

   function automatic logic load_use(input slot_t ex, input dec_t d, input logic [31:0] ins);
      if (!ex.memread || ex.rd == 5'd31) return 1'b0;
      return (d.use_rn && ins[9:5] == ex.rd) || (d.use_rm && ins[20:16] == ex.rd) ||
             (d.use_rt && ins[4:0] == ex.rd);
   endfunction

   // One clock: advance the model with the inputs held during the cycle, then apply new inputs.
   task automatic cycle(input logic rst, input logic [31:0] ins, input logic v, input logic bt);
      dec_t  d;
      logic  hz;
      exp_t  e;
      slot_t wbs;
      @(posedge CLOCK);
      d  = ref_decode(if_id_instr, if_id_valid);
      hz = load_use(m_ex, d, if_id_instr);
      if (RESET) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
         m_c_stall = 0; m_c_flush = 0; m_c_ret = 0;
      end else begin
         m_c_stall += 32'(hz && !branch_taken);
         m_c_flush += 32'(branch_taken);
         m_c_ret   += 32'(m_wb.regwrite || m_wb.memtoreg);
         wbs = '0;
         wbs.regwrite = m_mem.regwrite;
         wbs.memtoreg = m_mem.memtoreg;
         wbs.rd       = m_mem.rd;
         m_wb  = wbs;
         m_mem = branch_taken ? '0 : m_ex;
         m_ex  = (branch_taken || hz) ? '0 : d.s;
      end
      #1;
      RESET = rst; if_id_instr = ins; if_id_valid = v; branch_taken = bt;
      d = ref_decode(ins, v);
      e.stall   = load_use(m_ex, d, ins) && !bt;
      e.flush   = bt;
      e.illegal = v && !d.known;
      e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
      e.c_stall = m_c_stall; e.c_flush = m_c_flush; e.c_ret = m_c_ret;
      prev_stall = e.stall;
      prev_bt    = bt;
      sb_q.push_back(e);
   endtask

   always @(negedge CLOCK) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("comb{stall,flush,illegal}", {stall, flush_if_id, illegal_op},
             {e.stall, e.flush, e.illegal});
         chk("ex{reg2loc,alusrc,aluop,opcode}", {ex_reg2loc, ex_alusrc, ex_aluop, ex_opcode},
             {e.ex.reg2loc, e.ex.alusrc, e.ex.aluop, e.ex.op});
         chk("mem{rd,wr,br,ub}", {mem_memread, mem_memwrite, mem_branch, mem_uncon_branch},
             {e.mem.memread, e.mem.memwrite, e.mem.branch, e.mem.uncon});
         chk("wb{regwrite,memtoreg,rd}", {wb_regwrite, wb_memtoreg, wb_rd},
             {e.wb.regwrite, e.wb.memtoreg, e.wb.rd});
`ifdef PIPE_PERF_COUNTERS_EN
         chk("cnt_stall", cnt_stall, e.c_stall);
         chk("cnt_flush", cnt_flush, e.c_flush);
         chk("cnt_retired", cnt_retired, e.c_ret);
`endif
      end
   end

   function automatic logic [4:0] rreg();
      return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [10:0] op;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: op = 11'h7C2;
         1: op = 11'h7C0;
         2: op = {8'hB4, 3'($urandom_range(0, 7))};
         3: op = 11'h458;
         4: op = 11'h658;
         5: op = 11'h450;
         6: op = 11'h550;
         7: op = 11'h69B;
         8: op = 11'h69A;
         9: op = {6'b000101, 5'($urandom_range(0, 31))};
         default: op = 11'($urandom);
      endcase
      w[31:21] = op;
      w[20:16] = rreg();
      w[9:5]   = rreg();
      w[4:0]   = rreg();
      return w;
   endfunction

   initial begin
      logic [31:0] ins;
      logic        v, rst, bt;

      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      #1;
      chk("reset_state", {ex_alusrc, ex_aluop, ex_opcode, mem_memread, wb_regwrite, wb_rd}, 0);

      // load-use: one stall cycle, bubble in EX, ADD retires one cycle late
      cycle(0, I_LDUR_X1, 1, 0);
      cycle(0, I_ADD_X3, 1, 0);
      #1 chk("load_use_stall", stall, 1);
      cycle(0, I_ADD_X3, 1, 0);
      #1 chk("stall_one_cycle", stall, 0);
      chk("bubble_in_ex", {ex_alusrc, ex_aluop, ex_opcode}, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      #1 chk("add_wb", {wb_regwrite, wb_rd}, {1'b1, 5'd3});

      // load into XZR never stalls and never writes
      cycle(0, I_LDUR_XZR, 1, 0);
      cycle(0, I_ADD_XZR, 1, 0);
      #1 chk("xzr_no_stall", stall, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      #1 chk("xzr_ldur_wb", {wb_regwrite, wb_memtoreg, wb_rd}, {1'b0, 1'b1, 5'd31});

      // CBZ taken in MEM flushes the two younger instructions
      cycle(0, I_CBZ_X5, 1, 0);
      cycle(0, I_ADD_X7, 1, 0);
      cycle(0, I_ADD_X7, 1, 1);
      #1 chk("flush_if_id", {flush_if_id, mem_branch}, 2'b11);
      cycle(0, 0, 0, 0);
      #1 chk("flushed_ex_mem", {ex_alusrc, ex_aluop, ex_opcode, mem_memread, mem_memwrite,
                                mem_branch, mem_uncon_branch}, 0);
      chk("cbz_wb", {wb_regwrite, wb_memtoreg, wb_rd}, {2'b00, 5'd5});

      // flush beats a coincident load-use hazard
      cycle(0, I_LDUR_X1, 1, 0);
      cycle(0, I_ADD_X3, 1, 1);
      #1 chk("flush_over_stall", {stall, flush_if_id}, 2'b01);
      cycle(0, 0, 0, 0);

      cycle(0, I_ILLEGAL, 1, 0);
      #1 chk("illegal_op", illegal_op, 1);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      #1 chk("illegal_wb_zero", {wb_regwrite, wb_memtoreg}, 0);

      // reset in the middle of a stall
      cycle(0, I_LDUR_X1, 1, 0);
      cycle(1, I_ADD_X3, 1, 0);
      cycle(0, 0, 0, 0);
      #1 chk("reset_mid_stall", {stall, ex_alusrc, ex_aluop, ex_opcode, mem_memread,
                                 mem_memwrite, mem_branch, mem_uncon_branch,
                                 wb_regwrite, wb_memtoreg, wb_rd}, 0);
`ifdef PIPE_PERF_COUNTERS_EN
      chk("reset_counters", {cnt_stall, cnt_flush, cnt_retired}, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         bt  = ($urandom_range(0, 7) == 0);
         if (prev_stall) begin
            ins = if_id_instr;
            v   = if_id_valid;
         end else begin
            ins = rand_instr();
            v   = prev_bt ? 1'b0 : ($urandom_range(0, 9) != 0);
         end
         cycle(rst, ins, v, bt);
      end

      repeat (3) @(posedge CLOCK);
      chk("scoreboard_drained", 64'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
